i2s_dac_tx: RTL

- Parametrised I2S / left-justified serial audio transmitter for the APU audio output path. Replaces the fixed-rate, test-pattern DAC driver.
- Accepts stereo PCM samples from the APU mixer over a valid/ready handshake into a small FIFO.
- Generates AUD_BCLK and AUD_DACLRCK from the single system clock and serialises samples MSB-first on AUD_DACDAT.
- All logic runs in the clk domain using clock enables. BCLK and LRCK are outputs only and never clock internal flops.

---
 rtl/i2s_dac_tx_if.sv | 34 +++
 rtl/i2s_dac_tx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/i2s_dac_tx_if.sv
// Sample handshake between the APU mixer and the I2S DAC transmitter.
//   sample_l / sample_r : stereo PCM pair (two's complement)
//   sample_valid        : source offers a pair; must hold data until accepted
//   sample_ready        : transmitter FIFO has room
//   fifo_level          : number of occupied FIFO entries
// The mixer side uses modport master, the transmitter uses modport slave.
interface i2s_dac_tx_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] sample_l;
    logic [DATA_WIDTH-1:0] sample_r;
    logic                  sample_valid;
    logic                  sample_ready;
    logic [LvlW-1:0]       fifo_level;

    modport master (
        output sample_l,
        output sample_r,
        output sample_valid,
        input  sample_ready,
        input  fifo_level
    );

    modport slave (
        input  sample_l,
        input  sample_r,
        input  sample_valid,
        output sample_ready,
        output fifo_level
    );
endinterface

// File: rtl/i2s_dac_tx.sv
// I2S / left-justified serial audio transmitter.
// Stereo samples arrive over the smp handshake into a small FIFO. The block derives the bit
// clock (AUD_BCLK) and word select (AUD_DACLRCK) from clk with clock enables only, and shifts
// each channel word out MSB-first on AUD_DACDAT. A new frame is loaded on the rise of BCLK
// during the last bit of the right slot; an empty FIFO at that point plays silence and
// pulses underrun.
// Ports:
//   clk, rst_l   : system clock, asynchronous active-low reset
//   mode_i2s     : 1 = I2S (one-bit MSB delay), 0 = left-justified; latched at frame load
//   smp          : sample handshake (slave side), see i2s_dac_tx_if
//   underrun     : one-clk pulse when a frame loads with the FIFO empty
//   AUD_BCLK     : bit clock, period 2*BCLK_DIV clk
//   AUD_DACLRCK  : word select, 0 = left, 1 = right
//   AUD_DACDAT   : serial data, changes on BCLK falling events
module i2s_dac_tx #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SLOT_WIDTH = 32,
    parameter int unsigned BCLK_DIV   = 6,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              mode_i2s,
    i2s_dac_tx_if.slave       smp,
    output logic              underrun,
    output logic              AUD_BCLK,
    output logic              AUD_DACLRCK,
    output logic              AUD_DACDAT
);
    localparam int unsigned CntW = $clog2(2 * SLOT_WIDTH);
    localparam int unsigned DivW = $clog2(BCLK_DIV);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CntW-1:0] CntMax = CntW'(2 * SLOT_WIDTH - 1);
    localparam logic [CntW-1:0] SlotW  = CntW'(SLOT_WIDTH);
    localparam logic [CntW-1:0] DataW  = CntW'(DATA_WIDTH);
    localparam logic [DivW-1:0] DivMax = DivW'(BCLK_DIV - 1);
    localparam logic [LvlW-1:0] Full   = LvlW'(FIFO_DEPTH);

    if (SLOT_WIDTH <= DATA_WIDTH) begin : g_bad_slot
        $error("SLOT_WIDTH must exceed DATA_WIDTH");
    end
    if (BCLK_DIV < 2) begin : g_bad_div
        $error("BCLK_DIV must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    // Bit clock divider and events
    logic [DivW-1:0] div_q, div_d;
    logic            bclk_q, bclk_d;
    logic            div_wrap, rise_evt, fall_evt;

    // Serialiser state
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d, bit_nxt;
    logic            lrck_q, lrck_d;
    logic            dat_q, dat_d;
    logic            chan_r, in_word;
    logic [CntW-1:0] slot_pos, data_pos;
    logic [DATA_WIDTH-1:0] chan_word, word_shift;

    // Frame register
    logic [DATA_WIDTH-1:0] frame_l_q, frame_l_d;
    logic [DATA_WIDTH-1:0] frame_r_q, frame_r_d;
    logic                  frame_i2s_q, frame_i2s_d;
    logic                  underrun_q, underrun_d;
    logic                  load;

    // FIFO
    logic [DATA_WIDTH-1:0] mem_l [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]       count_q, count_d;
    logic                  push, pop;

    always_comb begin
        div_wrap = (div_q == DivMax);
        div_d    = div_wrap ? '0 : div_q + 1'b1;
        bclk_d   = bclk_q ^ div_wrap;
        rise_evt = div_wrap & ~bclk_q;
        fall_evt = div_wrap & bclk_q;
        load     = rise_evt & (bit_cnt_q == CntMax);
    end

    // FIFO occupancy uses the registered count, so a push in the load cycle cannot feed
    // that load.
    assign smp.sample_ready = (count_q != Full);
    assign smp.fifo_level   = count_q;

    always_comb begin
        push     = smp.sample_valid & smp.sample_ready;
        pop      = load & (count_q != '0);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        frame_l_d   = frame_l_q;
        frame_r_d   = frame_r_q;
        frame_i2s_d = frame_i2s_q;
        underrun_d  = 1'b0;
        if (load) begin
            frame_i2s_d = mode_i2s;
            if (pop) begin
                frame_l_d = mem_l[rd_ptr_q];
                frame_r_d = mem_r[rd_ptr_q];
            end else begin
                frame_l_d  = '0;
                frame_r_d  = '0;
                underrun_d = 1'b1;
            end
        end
    end

    // Data and word select are computed from the counter value after the fall-event advance.
    always_comb begin
        bit_nxt    = (bit_cnt_q == CntMax) ? '0 : bit_cnt_q + 1'b1;
        chan_r     = (bit_nxt >= SlotW);
        slot_pos   = chan_r ? bit_nxt - SlotW : bit_nxt;
        data_pos   = slot_pos - CntW'(frame_i2s_q);
        in_word    = (slot_pos >= CntW'(frame_i2s_q)) && (data_pos < DataW);
        chan_word  = chan_r ? frame_r_q : frame_l_q;
        word_shift = chan_word << data_pos;

        bit_cnt_d = bit_cnt_q;
        lrck_d    = lrck_q;
        dat_d     = dat_q;
        if (fall_evt) begin
            bit_cnt_d = bit_nxt;
            lrck_d    = chan_r;
            dat_d     = in_word & word_shift[DATA_WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            div_q       <= '0;
            bclk_q      <= 1'b0;
            bit_cnt_q   <= CntMax;
            lrck_q      <= 1'b0;
            dat_q       <= 1'b0;
            frame_l_q   <= '0;
            frame_r_q   <= '0;
            frame_i2s_q <= 1'b0;
            underrun_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            bit_cnt_q   <= bit_cnt_d;
            lrck_q      <= lrck_d;
            dat_q       <= dat_d;
            frame_l_q   <= frame_l_d;
            frame_r_q   <= frame_r_d;
            frame_i2s_q <= frame_i2s_d;
            underrun_q  <= underrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_l[wr_ptr_q] <= smp.sample_l;
            mem_r[wr_ptr_q] <= smp.sample_r;
        end
    end

    assign underrun    = underrun_q;
    assign AUD_BCLK    = bclk_q;
    assign AUD_DACLRCK = lrck_q;
    assign AUD_DACDAT  = dat_q;
endmodule
